// File: rtl/ahb2apb_mux_bridge.sv
// AHB-lite to APB3 bridge with an integrated NUM_SLV-way slave decoder/mux.
// Unmapped slots, slave errors and PREADY timeouts all produce a two-cycle AHB ERROR.
module ahb2apb_mux_bridge #(
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int SEL_W   = 4,
  parameter int PADDR_W = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADY,
  output logic [31:0]             HRDATA,
  output logic                    HREADYOUT,
  output logic [1:0]              HRESP,
  output logic [PADDR_W-1:0]      PADDR,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [32*NUM_SLV-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY,
  input  logic [NUM_SLV-1:0]      PSLVERR,
  output logic                    timeout_evt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] ERR1   = 3'd3;
  localparam logic [2:0] ERR2   = 3'd4;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] haddr_idx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             mapped;
  logic             apb_active;
  logic             timeout_hit;
  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_err;
  logic             unused_sig;

  assign haddr_idx = HADDR[SEL_LSB+SEL_W-1:SEL_LSB];
  assign mapped    = 32'(haddr_idx) < NUM_SLV;
  assign accept    = HSEL & HREADY & HTRANS[1] & ((state == IDLE) | (state == ERR2));
  assign unused_sig = ^{HADDR, HTRANS[0]};

  // Only the currently addressed slave's response lines are looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_rdata = PRDATA[32*i +: 32];
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !sel_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR2: begin
        if (accept) state_nxt = mapped ? SETUP : ERR1;
        else        state_nxt = IDLE;
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready)        state_nxt = sel_err ? ERR1 : IDLE;
        else if (timeout_hit) state_nxt = ERR1;
        else                  state_nxt = ACCESS;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= IDLE;
      idx         <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      cnt         <= '0;
      HRDATA      <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      timeout_evt <= (state == ACCESS) && timeout_hit;
      if (accept) begin
        idx    <= haddr_idx;
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
      end
      if (accept && mapped)      cnt <= '0;
      else if (state == ACCESS)  cnt <= cnt + 1'b1;
      // Read data is captured only on a good read; writes and errors leave it alone.
      if ((state == ACCESS) && sel_ready && !sel_err && !PWRITE)
        HRDATA <= sel_rdata;
    end
  end

  assign apb_active = (state == SETUP) || (state == ACCESS);

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = apb_active && (idx == SEL_W'(i));
    end
  end

  assign PENABLE   = (state == ACCESS);
  assign HREADYOUT = (state == IDLE) || (state == ERR2);
  assign HRESP     = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
  assign PWDATA    = HWDATA;

endmodule

// File: tb/tb_ahb2apb_mux_bridge.sv
// Randomised scoreboard bench for ahb2apb_mux_bridge: a TIMEOUT=4 instance carries
// the main traffic, a TIMEOUT=0 instance checks that a very slow slave is never aborted.
module tb_ahb2apb_mux_bridge;

  localparam int TMO_A  = 4;
  localparam logic [31:0] B_DATA = 32'h1357_9BDF;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          waits;
    int          acc;
    bit          apb;
    int          slot;
    logic [11:0] paddr;
    bit          write;
    logic [31:0] wdata;
    int          tmo;
  } exp_t;

  typedef struct {
    int          wait_n;
    bit          err;
    logic [31:0] data;
  } cfg_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        hsel_a = 1'b0;
  logic        hsel_b = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;

  logic [31:0]  a_hrdata, b_hrdata;
  logic         a_hreadyout, b_hreadyout;
  logic [1:0]   a_hresp, b_hresp;
  logic [11:0]  a_paddr, b_paddr;
  logic         a_penable, b_penable;
  logic         a_pwrite, b_pwrite;
  logic [31:0]  a_pwdata, b_pwdata;
  logic [3:0]   a_psel, b_psel;
  logic [127:0] a_prdata = '0;
  logic [3:0]   a_pready = '0;
  logic [3:0]   a_pslverr = '0;
  logic [127:0] b_prdata = {B_DATA, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
  logic [3:0]   b_pready = '0;
  logic [3:0]   b_pslverr = '0;
  logic         a_timeout_evt, b_timeout_evt;

  int          errors = 0;
  int          checks = 0;
  int          stray = 0;
  logic [31:0] model_rdata = '0;

  always #5 HCLK = ~HCLK;

  ahb2apb_mux_bridge #(.NUM_SLV(4), .SEL_LSB(12), .SEL_W(4), .PADDR_W(12), .TIMEOUT(TMO_A)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(a_hreadyout), .HRDATA(a_hrdata),
    .HREADYOUT(a_hreadyout), .HRESP(a_hresp), .PADDR(a_paddr), .PENABLE(a_penable),
    .PWRITE(a_pwrite), .PWDATA(a_pwdata), .PSEL(a_psel), .PRDATA(a_prdata),
    .PREADY(a_pready), .PSLVERR(a_pslverr), .timeout_evt(a_timeout_evt)
  );

  ahb2apb_mux_bridge #(.NUM_SLV(4), .SEL_LSB(12), .SEL_W(4), .PADDR_W(12), .TIMEOUT(0)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(b_hreadyout), .HRDATA(b_hrdata),
    .HREADYOUT(b_hreadyout), .HRESP(b_hresp), .PADDR(b_paddr), .PENABLE(b_penable),
    .PWRITE(b_pwrite), .PWDATA(b_pwdata), .PSEL(b_psel), .PRDATA(b_prdata),
    .PREADY(b_pready), .PSLVERR(b_pslverr), .timeout_evt(b_timeout_evt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one address phase (called at posedge+1), predicts its response from the
  // slave behaviour requested, and returns once the bus has accepted the address.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                               input bit write, input logic [31:0] wdata,
                               input int wait_n, input bit err, input logic [31:0] rdata);
    exp_t e;
    cfg_t c;
    int   slot;
    int   guard;
    slot   = int'(addr[15:12]);
    hsel_a = sel;
    htrans = trans;
    haddr  = addr;
    hwrite = write;
    if (sel) begin
      e.resp = 2'b00; e.rdata = model_rdata; e.waits = 0; e.acc = 0; e.apb = 0;
      e.slot = slot; e.paddr = addr[11:0]; e.write = write; e.wdata = wdata; e.tmo = 0;
      if (trans[1]) begin
        if (slot >= 4) begin
          e.resp = 2'b01; e.waits = 1;
        end else begin
          e.apb = 1;
          c.wait_n = wait_n; c.err = err; c.data = rdata;
          cfg_q.push_back(c);
          if (wait_n >= TMO_A) begin
            e.resp = 2'b01; e.acc = TMO_A; e.waits = TMO_A + 2; e.tmo = 1;
          end else if (err) begin
            e.resp = 2'b01; e.acc = wait_n + 1; e.waits = wait_n + 3;
          end else begin
            e.acc = wait_n + 1; e.waits = wait_n + 2;
            if (!write) model_rdata = rdata;
            e.rdata = model_rdata;
          end
        end
      end
      exp_q.push_back(e);
    end
    guard = 0;
    @(negedge HCLK);
    while (!a_hreadyout && guard < 1000) begin
      @(negedge HCLK);
      guard++;
    end
    if (guard >= 1000) checkOutput("addr_phase_wait", {31'd0, a_hreadyout}, 32'd1);
    @(posedge HCLK);
    #1;
    hwdata = wdata;
    hsel_a = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge HCLK);
      guard++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
    @(posedge HCLK);
    #1;
  endtask

  // APB slave model for the main instance: per-transfer wait count, error and data.
  initial begin
    cfg_t act;
    int   cnt;
    act.wait_n = 0; act.err = 0; act.data = '0;
    cnt = 0;
    forever begin
      @(posedge HCLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (a_psel[i] && !a_penable) begin
          if (cfg_q.size() > 0) act = cfg_q.pop_front();
          cnt = 0;
          a_pready[i]  = 1'($urandom_range(0, 1));
          a_pslverr[i] = 1'($urandom_range(0, 1));
        end else if (a_psel[i] && a_penable) begin
          a_pready[i]  = (cnt >= act.wait_n);
          a_pslverr[i] = a_pready[i] ? act.err : 1'($urandom_range(0, 1));
          a_prdata[32*i +: 32] = act.data;
          cnt++;
        end else begin
          a_pready[i]  = 1'($urandom_range(0, 1));
          a_pslverr[i] = 1'($urandom_range(0, 1));
          a_prdata[32*i +: 32] = $urandom;
        end
      end
    end
  end

  // Slow slave for the no-timeout instance: ready only after 300 ACCESS cycles.
  initial begin
    int b_cnt;
    b_cnt = 0;
    forever begin
      @(posedge HCLK);
      #1;
      if (b_penable) b_cnt++;
      else           b_cnt = 0;
      b_pready = (b_cnt > 300) ? 4'hF : 4'h0;
    end
  end

  // Monitor: follows each data phase of the main instance and scores it on completion.
  initial begin
    bit         in_data;
    int         wait_cnt, acc_cnt, setup_cnt, tmo_cnt;
    bit         apb_bad;
    logic [1:0] low_resp;
    exp_t       e;
    in_data = 0;
    wait_cnt = 0; acc_cnt = 0; setup_cnt = 0; tmo_cnt = 0; apb_bad = 0; low_resp = 2'b00;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        in_data = 0;
        continue;
      end
      if (a_hreadyout && (a_psel != 4'd0 || a_penable)) stray++;
      if (!in_data && a_timeout_evt) stray++;
      if (in_data) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_nonempty", exp_q.size(), 32'd1);
          in_data = 0;
        end else begin
          e = exp_q[0];
          if (a_timeout_evt) tmo_cnt++;
          if (!a_hreadyout) begin
            wait_cnt++;
            low_resp = a_hresp;
            if (a_psel != 4'd0) begin
              if (!e.apb || a_psel != (4'b0001 << e.slot) || a_paddr != e.paddr ||
                  a_pwrite != e.write || (e.write && a_pwdata != e.wdata))
                apb_bad = 1;
              if (a_penable) acc_cnt++;
              else           setup_cnt++;
            end
          end else begin
            void'(exp_q.pop_front());
            checkOutput("hresp", {30'd0, a_hresp}, {30'd0, e.resp});
            checkOutput("wait_states", wait_cnt, e.waits);
            checkOutput("hrdata", a_hrdata, e.rdata);
            if (e.waits > 0) checkOutput("hresp_low_phase", {30'd0, low_resp}, {30'd0, e.resp});
            checkOutput("access_cycles", acc_cnt, e.acc);
            checkOutput("setup_cycles", setup_cnt, e.apb ? 32'd1 : 32'd0);
            checkOutput("apb_signals", {31'd0, apb_bad}, 32'd0);
            checkOutput("timeout_evt", tmo_cnt, e.tmo);
            in_data = 0;
          end
        end
      end
      if (hsel_a && a_hreadyout) begin
        in_data = 1;
        wait_cnt = 0; acc_cnt = 0; setup_cnt = 0; tmo_cnt = 0; apb_bad = 0; low_resp = 2'b00;
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hreadyout"}, {31'd0, a_hreadyout}, 32'd1);
    checkOutput({tag, "_hresp"}, {30'd0, a_hresp}, 32'd0);
    checkOutput({tag, "_hrdata"}, a_hrdata, 32'd0);
    checkOutput({tag, "_psel"}, {28'd0, a_psel}, 32'd0);
    checkOutput({tag, "_penable"}, {31'd0, a_penable}, 32'd0);
    checkOutput({tag, "_paddr"}, {20'd0, a_paddr}, 32'd0);
    checkOutput({tag, "_pwrite"}, {31'd0, a_pwrite}, 32'd0);
    checkOutput({tag, "_timeout_evt"}, {31'd0, a_timeout_evt}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, addr, wd, rd;
    logic [1:0]  trans;
    int          guard, low, tmo_seen;

    #1 HRESET = 1'b1;
    #2 checkResetValues("reset");
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    $display("[TB] directed transfers");
    applyStimulus(1, 2'b10, 32'h0000_2010, 0, 32'h0, 0, 0, 32'hA5A5_1234);
    waitIdle();
    applyStimulus(1, 2'b10, 32'h0000_1004, 1, 32'hDEAD_BEEF, 3, 0, 32'h5555_AAAA);
    waitIdle();
    applyStimulus(1, 2'b10, 32'h0000_7000, 0, 32'h0, 0, 0, 32'h0);
    waitIdle();
    applyStimulus(1, 2'b10, 32'h0000_0008, 0, 32'h0, 0, 1, 32'h0BAD_0BAD);
    waitIdle();
    applyStimulus(1, 2'b10, 32'h0000_3000, 0, 32'h0, 50, 0, 32'h3333_3333);
    waitIdle();
    applyStimulus(1, 2'b10, 32'h0000_3ABC, 0, 32'h0, TMO_A - 1, 0, 32'h7777_0001);
    waitIdle();
    applyStimulus(1, 2'b00, 32'h0000_2000, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 2'b01, 32'h0000_2000, 1, 32'h1, 0, 0, 32'h0);
    applyStimulus(0, 2'b10, 32'h0000_2000, 1, 32'h2, 0, 0, 32'h0);
    waitIdle();

    $display("[TB] random traffic");
    for (int n = 0; n < 80; n++) begin
      addr = $urandom;
      r = $urandom_range(0, 7);
      addr[15:12] = r[3:0];
      r = $urandom_range(0, 7);
      trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r[0] ? 2'b11 : 2'b10);
      wd = $urandom;
      rd = $urandom;
      applyStimulus(1, trans, addr, bit'($urandom_range(0, 1)), wd,
                    $urandom_range(0, 5), ($urandom_range(0, 3) == 0), rd);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge HCLK); #1;
      end
    end
    waitIdle();

    $display("[TB] reset during ACCESS");
    applyStimulus(1, 2'b10, 32'h0000_2044, 0, 32'h0, 3, 0, 32'hCAFE_0001);
    guard = 0;
    @(negedge HCLK);
    while (!a_penable && guard < 20) begin
      @(negedge HCLK);
      guard++;
    end
    checkOutput("reach_access", {31'd0, a_penable}, 32'd1);
    #2 HRESET = 1'b1;
    #1 checkResetValues("async_reset");
    exp_q.delete();
    cfg_q.delete();
    model_rdata = '0;
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    applyStimulus(1, 2'b10, 32'h0000_0100, 0, 32'h0, 0, 0, 32'h0000_00A0);
    applyStimulus(1, 2'b10, 32'h0000_1200, 0, 32'h0, 0, 0, 32'h0000_01B1);
    waitIdle();

    $display("[TB] no-timeout instance with 300-cycle slave");
    hsel_b = 1'b1; htrans = 2'b10; haddr = 32'h0000_3008; hwrite = 1'b0;
    @(posedge HCLK); #1;
    hsel_b = 1'b0; htrans = 2'b00;
    low = 0; tmo_seen = 0; guard = 0;
    @(negedge HCLK);
    while (!b_hreadyout && guard < 400) begin
      low++;
      if (b_timeout_evt) tmo_seen++;
      @(negedge HCLK);
      guard++;
    end
    if (b_timeout_evt) tmo_seen++;
    checkOutput("b_wait_states", low, 32'd302);
    checkOutput("b_hresp", {30'd0, b_hresp}, 32'd0);
    checkOutput("b_hrdata", b_hrdata, B_DATA);
    checkOutput("b_timeout_evt", tmo_seen, 32'd0);
    @(posedge HCLK); #1;

    checkOutput("stray_activity", stray, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
